// File: rtl/adc_sequencer.sv
// Scan sequencer for an LTC2308-style SAR ADC: convst/sck/sdi generation, result capture,
// and one-frame pipeline realignment of channel and data toward the adder.
module adc_sequencer #(
    parameter int NCHANNELS    = 8,
    parameter int SCK_HALF     = 2,
    parameter int TCONV        = 80,
    parameter int FRAME_PERIOD = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  channel_mask,
    input  logic        uni,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [2:0]  channel,
    output logic [11:0] data,
    output logic        data_ready,
    output logic        busy
);
    localparam int FW = $clog2(FRAME_PERIOD + 1);
    localparam int TW = $clog2(TCONV + SCK_HALF + 1);
    localparam logic [7:0] CH_EN = 8'((9'd1 << NCHANNELS) - 9'd1);

    // IDLE off | CONVST 2-clk start pulse | CONV wait TCONV | SHIFT 12 sck | DONE load | WAIT frame gap
    typedef enum logic [2:0] {S_IDLE, S_CONVST, S_CONV, S_SHIFT, S_DONE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    bit_q, bit_d;
    logic          sck_q, sck_d;
    logic [11:0]   cfg_q, cfg_d;
    logic [11:0]   shift_q, shift_d;
    logic [2:0]    cur_ch_q, cur_ch_d;
    logic [2:0]    prev_ch_q, prev_ch_d;
    logic          prime_q, prime_d;
    logic [1:0]    dr_q, dr_d;
    logic [2:0]    channel_q, channel_d;
    logic [11:0]   data_q, data_d;
    logic          convst_q, busy_q;

    logic [7:0] mask_eff;
    logic [2:0] base, cand, next_ch;
    logic       found, start;

    always_comb begin
        mask_eff = channel_mask & CH_EN;
        base     = (state_q == S_IDLE) ? 3'd7 : cur_ch_q;
        next_ch  = base;
        cand     = '0;
        found    = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = base + 3'(i);
            if (!found && mask_eff[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = (frame_q != '0) ? frame_q - 1'b1 : frame_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        sck_d     = sck_q;
        cfg_d     = cfg_q;
        shift_d   = shift_q;
        cur_ch_d  = cur_ch_q;
        prev_ch_d = prev_ch_q;
        prime_d   = prime_q;
        dr_d      = (dr_q != 2'd0) ? dr_q - 2'd1 : dr_q;
        channel_d = channel_q;
        data_d    = data_q;
        start     = 1'b0;
        case (state_q)
            S_IDLE: if (enable && mask_eff != 8'd0) start = 1'b1;
            S_CONVST: begin
                if (tmr_q == '0) begin
                    state_d = S_CONV;
                    tmr_d   = TW'(TCONV - 3);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_CONV: begin
                if (tmr_q == '0) begin
                    state_d = S_SHIFT;
                    tmr_d   = TW'(SCK_HALF - 1);
                    bit_d   = 4'd0;
                    sck_d   = 1'b1;
                    shift_d = {shift_q[10:0], adc_sdo};
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SHIFT: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (sck_q) begin
                    sck_d = 1'b0;
                    tmr_d = TW'(SCK_HALF - 1);
                    cfg_d = {cfg_q[10:0], 1'b0};
                end else if (bit_q == 4'd11) begin
                    state_d = S_DONE;
                end else begin
                    sck_d   = 1'b1;
                    tmr_d   = TW'(SCK_HALF - 1);
                    bit_d   = bit_q + 4'd1;
                    shift_d = {shift_q[10:0], adc_sdo};
                end
            end
            S_DONE: begin
                state_d = S_WAIT;
                prime_d = 1'b0;
                if (!prime_q) begin
                    channel_d = prev_ch_q;
                    data_d    = shift_q;
                    dr_d      = 2'd2;
                end
            end
            S_WAIT: begin
                // Leave only after the result strobe has finished.
                if (!enable) begin
                    if (dr_q <= 2'd1) begin
                        state_d = S_IDLE;
                        prime_d = 1'b1;
                    end
                end else if (frame_q == '0) begin
                    if (mask_eff != 8'd0) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        prime_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d   = S_CONVST;
            frame_d   = FW'(FRAME_PERIOD - 1);
            tmr_d     = TW'(1);
            prev_ch_d = cur_ch_q;
            cur_ch_d  = next_ch;
            cfg_d     = {1'b1, next_ch[0], next_ch[2], next_ch[1], uni, 7'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            tmr_q     <= '0;
            bit_q     <= 4'd0;
            sck_q     <= 1'b0;
            cfg_q     <= 12'd0;
            shift_q   <= 12'd0;
            cur_ch_q  <= 3'd7;
            prev_ch_q <= 3'd0;
            prime_q   <= 1'b1;
            dr_q      <= 2'd0;
            channel_q <= 3'd0;
            data_q    <= 12'd0;
            convst_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            cfg_q     <= cfg_d;
            shift_q   <= shift_d;
            cur_ch_q  <= cur_ch_d;
            prev_ch_q <= prev_ch_d;
            prime_q   <= prime_d;
            dr_q      <= dr_d;
            channel_q <= channel_d;
            data_q    <= data_d;
            convst_q  <= (state_d == S_CONVST);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign adc_convst = convst_q;
    assign adc_sck    = sck_q;
    assign adc_sdi    = cfg_q[11];
    assign channel    = channel_q;
    assign data       = data_q;
    assign data_ready = (dr_q != 2'd0);
    assign busy       = busy_q;
endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: two instances (default frame period and a short back-to-back one),
// behavioural LTC2308 models, and a scan-order/pipeline reference computed from the channel mask.
module tb_adc_sequencer;
    localparam int FP0     = 200;
    localparam int FP1     = 100;
    localparam int TC      = 80;
    localparam int SH      = 2;
    // Frame length when the period is too short: convst rise to DONE, plus one WAIT cycle.
    localparam int B2B_PER = TC + 24 * SH + 2;

    logic        clk, reset_n, uni;
    logic [7:0]  channel_mask;
    logic        en [2];
    logic        convst_w [2], sck_w [2], sdi_w [2], sdo_w [2], dr_w [2], busy_w [2];
    logic [2:0]  ch_w [2];
    logic [11:0] dat_w [2];
    logic [11:0] adc_val [8];
    int total = 0, bad = 0;

    adc_sequencer dut0 (
        .clk(clk), .reset_n(reset_n), .enable(en[0]), .channel_mask(channel_mask), .uni(uni),
        .adc_convst(convst_w[0]), .adc_sck(sck_w[0]), .adc_sdi(sdi_w[0]), .adc_sdo(sdo_w[0]),
        .channel(ch_w[0]), .data(dat_w[0]), .data_ready(dr_w[0]), .busy(busy_w[0])
    );

    adc_sequencer #(.NCHANNELS(8), .SCK_HALF(SH), .TCONV(TC), .FRAME_PERIOD(FP1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(en[1]), .channel_mask(channel_mask), .uni(uni),
        .adc_convst(convst_w[1]), .adc_sck(sck_w[1]), .adc_sdi(sdi_w[1]), .adc_sdo(sdo_w[1]),
        .channel(ch_w[1]), .data(dat_w[1]), .data_ready(dr_w[1]), .busy(busy_w[1])
    );

    always #5 clk = ~clk;

    // ADC model: result of the channel configured during the previous shift, MSB first.
    for (genvar g = 0; g < 2; g++) begin : g_adc
        logic [11:0] sr  = '0;
        logic [11:0] cw  = '0;
        logic [2:0]  cch = '0;
        int          nb  = 0;
        always @(posedge convst_w[g] or posedge sck_w[g] or negedge sck_w[g]) begin
            if (convst_w[g]) begin
                sr = adc_val[cch];
                nb = 0;
            end else if (sck_w[g]) begin
                cw = {cw[10:0], sdi_w[g]};
                nb = nb + 1;
                if (nb == 12) cch = {cw[9], cw[8], cw[10]};
            end else begin
                sr = {sr[10:0], 1'b0};
            end
        end
        assign sdo_w[g] = sr[11];
    end

    task automatic run_scan(input int d, input logic [7:0] mask_v, input int nframes, input bit seq_data);
        int sb[$];
        int rise_t[$];
        logic [11:0] words[$];
        logic [2:0] rch[$];
        logic [11:0] rdat[$];
        int cyc, width, drlen, viol, nb, exp_per, limit, k, n;
        logic cv_p, sck_p, dr_p, sdi_p, u;
        logic [11:0] w, exp_w, exp_d;
        logic [2:0] exp_c;
        cyc = 0; width = 0; drlen = 0; viol = 0; nb = 0; w = '0;
        cv_p = 0; sck_p = 0; dr_p = 0; sdi_p = sdi_w[d];
        exp_per = (d == 0) ? FP0 : B2B_PER;
        limit = nframes * (exp_per + 50) + 500;
        for (int i = 0; i < 8; i++) if (mask_v[i]) sb.push_back(i);
        n = sb.size();
        for (int c = 0; c < 8; c++) adc_val[c] = seq_data ? 12'(12'h100 + c) : 12'($urandom);
        u = 1'($urandom);
        uni = u;
        channel_mask = mask_v;
        @(negedge clk);
        en[d] = 1'b1;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (convst_w[d] && !cv_p) begin
                rise_t.push_back(cyc);
                nb = 0;
            end
            if (convst_w[d]) begin
                width++;
                if (!busy_w[d]) viol++;
            end else if (cv_p) begin
                if (width != 2) viol++;
                width = 0;
            end
            if (rise_t.size() > 0) begin
                k = cyc - rise_t[$];
                if (k == 10) begin channel_mask = 8'($urandom); uni = 1'($urandom); end
                if (k == 100) begin channel_mask = mask_v; uni = u; end
                if (k == 5 && rise_t.size() == nframes) en[d] = 1'b0;
            end
            if (sck_w[d] && !sck_p) begin
                w = {w[10:0], sdi_w[d]};
                nb++;
                if (nb == 12) begin words.push_back(w); nb = 0; end
            end
            if (sck_w[d] && sdi_w[d] !== sdi_p) viol++;
            if (dr_w[d] && !dr_p) begin
                rch.push_back(ch_w[d]);
                rdat.push_back(dat_w[d]);
                drlen = 0;
            end
            if (dr_w[d]) drlen++;
            if (rch.size() > 0 && (ch_w[d] !== rch[$] || dat_w[d] !== rdat[$])) viol++;
            if (!dr_w[d] && dr_p) begin
                if (drlen != 2) viol++;
                if (!en[d]) begin
                    total++;
                    if (busy_w[d] !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_after_last_ready dut%0d: busy=%0b want 0", d, busy_w[d]);
                    end
                end
            end
            cv_p = convst_w[d]; sck_p = sck_w[d]; dr_p = dr_w[d]; sdi_p = sdi_w[d];
            if (!en[d] && !busy_w[d] && rise_t.size() >= nframes) break;
        end
        en[d] = 1'b0;
        total++;
        if (cyc >= limit) begin bad++; $display("FAIL scan_timeout dut%0d: cycles=%0d limit=%0d", d, cyc, limit); end
        total++;
        if (rise_t.size() != nframes) begin
            bad++; $display("FAIL frame_count dut%0d: got %0d want %0d", d, rise_t.size(), nframes);
        end
        for (int i = 1; i < rise_t.size(); i++) begin
            total++;
            if (rise_t[i] - rise_t[i-1] != exp_per) begin
                bad++; $display("FAIL convst_period dut%0d #%0d: got %0d want %0d", d, i, rise_t[i] - rise_t[i-1], exp_per);
            end
        end
        total++;
        if (words.size() != nframes) begin
            bad++; $display("FAIL sdi_word_count dut%0d: got %0d want %0d", d, words.size(), nframes);
        end
        for (int j = 0; j < words.size(); j++) begin
            exp_c = 3'(sb[j % n]);
            exp_w = {1'b1, exp_c[0], exp_c[2], exp_c[1], u, 7'b0};
            total++;
            if (words[j] !== exp_w) begin
                bad++; $display("FAIL sdi_word dut%0d #%0d: got %03h want %03h", d, j, words[j], exp_w);
            end
        end
        total++;
        if (rch.size() != nframes - 1) begin
            bad++; $display("FAIL report_count dut%0d: got %0d want %0d", d, rch.size(), nframes - 1);
        end
        for (int j = 0; j < rch.size(); j++) begin
            exp_c = 3'(sb[j % n]);
            exp_d = adc_val[exp_c];
            total++;
            if (rch[j] !== exp_c || rdat[j] !== exp_d) begin
                bad++; $display("FAIL report dut%0d #%0d: got ch%0d/%03h want ch%0d/%03h", d, j, rch[j], rdat[j], exp_c, exp_d);
            end
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL protocol dut%0d: violations=%0d want 0", d, viol); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({convst_w[d], sck_w[d], sdi_w[d], dr_w[d], busy_w[d]} !== 5'b0) begin
                bad++; $display("FAIL reset_ctrl dut%0d: got %05b want 00000", d, {convst_w[d], sck_w[d], sdi_w[d], dr_w[d], busy_w[d]});
            end
            total++;
            if (ch_w[d] !== 3'd0 || dat_w[d] !== 12'd0) begin
                bad++; $display("FAIL reset_result dut%0d: got ch%0d/%03h want ch0/000", d, ch_w[d], dat_w[d]);
            end
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%0b want 0", busy_w[0]); end
    endtask

    task automatic test_mask_ff();
        run_scan(0, 8'hFF, 10, 1'b1);
    endtask

    task automatic test_mask_24();
        run_scan(0, 8'h24, 6, 1'b0);
    endtask

    task automatic test_random_masks();
        for (int r = 0; r < 3; r++)
            run_scan(0, 8'($urandom_range(1, 255)), int'($urandom_range(2, 6)), 1'b0);
    endtask

    task automatic test_mask_zero();
        int cv = 0, bz = 0;
        channel_mask = 8'h00;
        en[0] = 1'b1;
        repeat (400) begin
            @(negedge clk);
            if (convst_w[0]) cv++;
            if (busy_w[0]) bz++;
        end
        en[0] = 1'b0;
        total++;
        if (cv != 0) begin bad++; $display("FAIL mask_zero_convst: high cycles=%0d want 0", cv); end
        total++;
        if (bz != 0) begin bad++; $display("FAIL mask_zero_busy: busy cycles=%0d want 0", bz); end
    endtask

    task automatic test_reset_mid_shift();
        int cyc = 0, rises = 0, scks = 0, reps = 0;
        logic cv_p = 0, sck_p = 0;
        channel_mask = 8'hFF;
        uni = 1'b0;
        en[0] = 1'b1;
        while (cyc < 1000 && !(rises == 2 && scks == 7)) begin
            @(negedge clk);
            cyc++;
            if (convst_w[0] && !cv_p) begin rises++; scks = 0; end
            if (sck_w[0] && !sck_p) scks++;
            if (dr_w[0]) reps++;
            cv_p = convst_w[0]; sck_p = sck_w[0];
        end
        total++;
        if (cyc >= 1000) begin bad++; $display("FAIL reach_bit6 timeout: cycles=%0d", cyc); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({convst_w[0], sck_w[0], sdi_w[0], dr_w[0], busy_w[0]} !== 5'b0) begin
            bad++; $display("FAIL async_reset_ctrl: got %05b want 00000", {convst_w[0], sck_w[0], sdi_w[0], dr_w[0], busy_w[0]});
        end
        total++;
        if (ch_w[0] !== 3'd0 || dat_w[0] !== 12'd0) begin
            bad++; $display("FAIL async_reset_result: got ch%0d/%03h want ch0/000", ch_w[0], dat_w[0]);
        end
        repeat (3) begin
            @(negedge clk);
            if (dr_w[0]) reps++;
        end
        total++;
        if (reps != 0) begin bad++; $display("FAIL aborted_frame_ready: pulses=%0d want 0", reps); end
        en[0] = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run_scan(0, 8'hFF, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_scan(1, 8'($urandom_range(1, 255)), 8, 1'b0);
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b1;
        en[0] = 1'b0;
        en[1] = 1'b0;
        channel_mask = 8'h00;
        uni = 1'b0;
        for (int c = 0; c < 8; c++) adc_val[c] = 12'd0;
        test_reset();
        test_mask_ff();
        test_mask_24();
        test_random_masks();
        test_mask_zero();
        test_reset_mid_shift();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
